// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Mode-0 (CPOL=0, CPHA=0), MSB-first, byte-oriented SPI responder. All SPI pins
// are oversampled in the clk domain. The user side has a single-entry TX
// holding register (valid/ready) and a one-cycle RX byte strobe.
//
// Parameters
//   SYNC_STAGES  flops per input synchroniser (2 or 3)
//   IDLE_BYTE    byte shifted out when the holding register is empty at a
//                byte boundary
//
// Ports
//   clk          system clock (only clock)
//   reset        synchronous, active-high reset
//   s_clk        SPI clock from master (asynchronous)
//   s_csn        SPI chip select, active low (asynchronous)
//   s_mosi       master-out data (asynchronous)
//   s_miso       slave-out data (registered)
//   tx_data      next byte to transmit
//   tx_valid     tx_data valid; accepted when tx_valid && tx_ready
//   tx_ready     holding register empty
//   rx_data      last fully received byte
//   rx_valid     one-cycle pulse, rx_data just updated
//   tx_underrun  one-cycle pulse, IDLE_BYTE loaded because holding reg empty
//   cs_active    synchronised, inverted s_csn
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_clk,
  input  logic       s_csn,
  input  logic       s_mosi,
  output logic       s_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       cs_active
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Input synchronisers
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic sclk_s;
  logic csn_s;
  logic mosi_s;

  // Edge detection
  logic sclk_prev_q;
  logic csn_prev_q;
  logic rise_q;
  logic fall_q;
  logic cs_fall_s;

  // Protocol state
  state_e      state_q,      state_d;
  logic [2:0]  bit_cnt_q,    bit_cnt_d;
  logic [7:0]  rx_shift_q,   rx_shift_d;
  logic [7:0]  tx_shift_q,   tx_shift_d;
  logic [7:0]  hold_q,       hold_d;
  logic        full_q,       full_d;
  logic        byte_done_q,  byte_done_d;
  logic [7:0]  rx_data_q,    rx_data_d;
  logic        rx_valid_q,   rx_valid_d;
  logic        underrun_q,   underrun_d;
  logic        miso_q,       miso_d;
  logic        cs_active_q,  cs_active_d;
  logic        tx_ready_q,   tx_ready_d;

  logic        load_s;
  logic        write_s;

  // Shift each asynchronous SPI pin through its synchroniser chain.
  // s_csn resets to 1 (deselected), s_clk/s_mosi reset to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  s_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], s_mosi};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Select is detected from the live synchronised level; the s_clk edges are
  // registered once more, which puts rx_valid SYNC_STAGES+1 cycles after the
  // first sample of the 8th high s_clk.
  assign cs_fall_s = ~csn_s & csn_prev_q;

  // Previous-value registers and registered s_clk edge strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      fall_q      <= ~sclk_s & sclk_prev_q;
    end
  end

  assign write_s = tx_valid & tx_ready_q;

  // Next-state logic: IDLE/ACTIVE FSM, shift registers, holding register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    full_d      = full_q;
    byte_done_d = byte_done_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    load_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d     = ST_ACTIVE;
          load_s      = 1'b1;
          bit_cnt_d   = 3'd0;
          byte_done_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (csn_s) begin
          // Deselect wins over a coincident edge; partial byte is dropped.
          state_d     = ST_IDLE;
          bit_cnt_d   = 3'd0;
          rx_shift_d  = 8'h00;
          byte_done_d = 1'b0;
        end else if (rise_q) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {rx_shift_q[6:0], mosi_s};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (fall_q) begin
          if (byte_done_q) begin
            load_s      = 1'b1;
            byte_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Byte-boundary load: take the holding register if full, else IDLE_BYTE.
    if (load_s) begin
      if (full_q) begin
        tx_shift_d = hold_q;
        full_d     = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end else begin
      underrun_d = 1'b0;
    end

    // A write only happens while empty, so it never collides with a full-load;
    // a write coinciding with an underrun load is kept for the next boundary.
    if (write_s) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end

    tx_ready_d  = ~full_d;
    cs_active_d = ~csn_s;
    if (state_d == ST_ACTIVE) begin
      miso_d = tx_shift_d[7];
    end else begin
      miso_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      full_q      <= 1'b0;
      byte_done_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      cs_active_q <= 1'b0;
      tx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      byte_done_q <= byte_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      cs_active_q <= cs_active_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

  assign s_miso      = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign cs_active   = cs_active_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed bench for spi_slave acting as a mode-0 SPI master. Inputs change on
// the falling clk edge; outputs are sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int SYNC    = 2;
  localparam int HP_SLOW = 6;
  localparam int HP_FAST = SYNC + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_clk;
  logic       s_csn;
  logic       s_mosi;
  logic       s_miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       cs_active;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int hp = HP_SLOW;
  int rx_pulses = 0;
  int ur_pulses = 0;
  int base_rx;
  int base_ur;
  logic [7:0] m;
  logic [7:0] mo;
  logic [7:0] txq [0:63];

  spi_slave #(
    .SYNC_STAGES (SYNC),
    .IDLE_BYTE   (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_clk       (s_clk),
    .s_csn       (s_csn),
    .s_mosi      (s_mosi),
    .s_miso      (s_miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .cs_active   (cs_active)
  );

  // Free-running system clock.
  initial forever #5 clk = ~clk;

  // Count strobe pulses (each high cycle counts once).
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_pulses <= rx_pulses + 1;
    if (tx_underrun === 1'b1) ur_pulses <= ur_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    int waited = 0;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready === 1'b1) begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end else begin
      check_eq("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    end
  endtask

  task automatic spi_select();
    s_csn = 1'b0;
    cycles(hp);
  endtask

  task automatic spi_deselect();
    cycles(hp);
    s_csn  = 1'b1;
    s_mosi = 1'b0;
    cycles(2 * hp);
  endtask

  task automatic spi_xfer(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      s_mosi = mosi_b[7-i];
      cycles(hp);
      miso_b[7-i] = s_miso;
      s_clk = 1'b1;
      cycles(hp);
      s_clk = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    s_clk    = 1'b0;
    s_csn    = 1'b1;
    s_mosi   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    cycles(3);

    // Reset state
    check_eq("rst_miso",     {31'd0, s_miso},      32'd0);
    check_eq("rst_rx_data",  {24'd0, rx_data},     32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid},    32'd0);
    check_eq("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check_eq("rst_cs_act",   {31'd0, cs_active},   32'd0);
    check_eq("rst_tx_ready", {31'd0, tx_ready},    32'd0);
    reset = 1'b0;
    cycles(1);
    check_eq("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);

    // Test 1: single byte, MOSI 0xA5, holding register preloaded 0x3C
    base_rx = rx_pulses;
    base_ur = ur_pulses;
    tx_write(8'h3C);
    check_eq("t1_full_ready", {31'd0, tx_ready}, 32'd0);
    spi_select();
    check_eq("t1_sel_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("t1_cs_active", {31'd0, cs_active}, 32'd1);
    check_eq("t1_sel_ur", ur_pulses - base_ur, 32'd0);
    spi_xfer(8'hA5, 8, m);
    check_eq("t1_miso", {24'd0, m}, 32'h3C);
    check_eq("t1_rx_data", {24'd0, rx_data}, 32'hA5);
    check_eq("t1_rx_pulses", rx_pulses - base_rx, 32'd1);
    spi_deselect();
    check_eq("t1_end_ur", ur_pulses - base_ur, 32'd1);
    check_eq("t1_desel_cs", {31'd0, cs_active}, 32'd0);
    check_eq("t1_desel_miso", {31'd0, s_miso}, 32'd0);

    // Test 2: back-to-back bytes, 0x11 written during byte 1
    base_rx = rx_pulses;
    base_ur = ur_pulses;
    tx_write(8'h3C);
    spi_select();
    tx_write(8'h11);
    spi_xfer(8'h01, 8, m);
    check_eq("t2_miso0", {24'd0, m}, 32'h3C);
    check_eq("t2_rx0", {24'd0, rx_data}, 32'h01);
    check_eq("t2_pulses0", rx_pulses - base_rx, 32'd1);
    spi_xfer(8'h80, 8, m);
    check_eq("t2_miso1", {24'd0, m}, 32'h11);
    check_eq("t2_rx1", {24'd0, rx_data}, 32'h80);
    check_eq("t2_pulses1", rx_pulses - base_rx, 32'd2);
    spi_deselect();
    check_eq("t2_ur", ur_pulses - base_ur, 32'd1);

    // Test 3: select while empty -> IDLE_BYTE and underrun; later write held
    base_rx = rx_pulses;
    base_ur = ur_pulses;
    spi_select();
    check_eq("t3_sel_ur", ur_pulses - base_ur, 32'd1);
    tx_write(8'h5A);
    spi_xfer(8'hC3, 8, m);
    check_eq("t3_miso0", {24'd0, m}, 32'h00);
    check_eq("t3_rx0", {24'd0, rx_data}, 32'hC3);
    spi_xfer(8'h3C, 8, m);
    check_eq("t3_miso1", {24'd0, m}, 32'h5A);
    spi_deselect();
    check_eq("t3_ur", ur_pulses - base_ur, 32'd2);
    check_eq("t3_pulses", rx_pulses - base_rx, 32'd2);

    // Test 4: deselect after 5 clocks, then full bytes realign
    base_rx = rx_pulses;
    spi_select();
    spi_xfer(8'hB7, 5, m);
    spi_deselect();
    check_eq("t4_partial_pulses", rx_pulses - base_rx, 32'd0);
    check_eq("t4_partial_rx", {24'd0, rx_data}, 32'h3C);
    spi_select();
    spi_xfer(8'hFF, 8, m);
    check_eq("t4_rx_ff", {24'd0, rx_data}, 32'hFF);
    check_eq("t4_miso_ff", {24'd0, m}, 32'h00);
    spi_xfer(8'h69, 8, m);
    check_eq("t4_rx_69", {24'd0, rx_data}, 32'h69);
    check_eq("t4_pulses", rx_pulses - base_rx, 32'd2);
    spi_deselect();

    // Test 5: reset pulse mid-byte
    tx_write(8'h77);
    spi_select();
    tx_write(8'h88);
    base_rx = rx_pulses;
    spi_xfer(8'hAA, 4, m);
    check_eq("t5_miso_part", {24'd0, m}, 32'h70);
    reset = 1'b1;
    cycles(1);
    check_eq("t5_rst_miso",     {31'd0, s_miso},      32'd0);
    check_eq("t5_rst_rx_data",  {24'd0, rx_data},     32'd0);
    check_eq("t5_rst_rx_valid", {31'd0, rx_valid},    32'd0);
    check_eq("t5_rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check_eq("t5_rst_cs_act",   {31'd0, cs_active},   32'd0);
    check_eq("t5_rst_tx_ready", {31'd0, tx_ready},    32'd0);
    reset = 1'b0;
    cycles(1);
    check_eq("t5_post_tx_ready", {31'd0, tx_ready}, 32'd1);
    spi_deselect();
    check_eq("t5_no_rx", rx_pulses - base_rx, 32'd0);
    base_rx = rx_pulses;
    spi_select();
    spi_xfer(8'h5C, 8, m);
    check_eq("t5_rx", {24'd0, rx_data}, 32'h5C);
    check_eq("t5_miso", {24'd0, m}, 32'h00);
    check_eq("t5_pulses", rx_pulses - base_rx, 32'd1);
    spi_deselect();

    // Test 6: minimum half-period, 64 random transfers
    hp = HP_FAST;
    for (int i = 0; i < 64; i++) txq[i] = 8'($urandom_range(0, 255));
    base_rx = rx_pulses;
    tx_write(txq[0]);
    spi_select();
    for (int i = 0; i < 64; i++) begin
      mo = 8'($urandom_range(0, 255));
      fork
        spi_xfer(mo, 8, m);
        begin
          if (i < 63) tx_write(txq[i+1]);
        end
      join
      check_eq("t6_miso", {24'd0, m}, {24'd0, txq[i]});
      check_eq("t6_rx", {24'd0, rx_data}, {24'd0, mo});
    end
    spi_deselect();
    check_eq("t6_pulses", rx_pulses - base_rx, 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
